// File: rtl/pragmatic_weight_encoder_pkg.sv
// Shared constants, types and the lowest-set-bit helper for the Pragmatic weight encoder.
package pragmatic_pkg;
  localparam int MAG_WIDTH = 7;
  localparam int WINDOW    = 4;
  localparam int BASE_MAX  = 3;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [1:0] sel;
    logic       en;
    logic       neg;
  } lane_cmd_t;

  // Returns 7 for an empty mask so it never wins a min() against a real bit position.
  function automatic logic [2:0] lsb_pos(input logic [MAG_WIDTH-1:0] m);
    lsb_pos = 3'd7;
    for (int i = MAG_WIDTH-1; i >= 0; i--)
      if (m[i]) lsb_pos = 3'(i);
  endfunction
endpackage

// File: rtl/pragmatic_weight_encoder_lane_pick.sv
// One lane of the scheduler: decides whether the lowest essential bit fits the window above base.
module pragmatic_lane_pick
  import pragmatic_pkg::*;
(
  input  logic [MAG_WIDTH-1:0] i_mask,
  input  logic [1:0]           i_base,
  output logic                 o_fire,
  output logic [1:0]           o_s1,
  output logic [MAG_WIDTH-1:0] o_mask_nxt
);
  logic [2:0] w_pos;
  logic [2:0] w_off;

  always_comb begin
    w_pos      = lsb_pos(i_mask);
    w_off      = w_pos - {1'b0, i_base};
    o_fire     = (i_mask != '0) && (w_off <= 3'(WINDOW-1));
    o_s1       = o_fire ? w_off[1:0] : 2'd0;
    o_mask_nxt = o_fire ? (i_mask & (i_mask - MAG_WIDTH'(1))) : i_mask;
  end
endmodule

// File: rtl/pragmatic_weight_encoder.sv
// Double-buffered weight group encoder issuing one Pragmatic MAC command per cycle.
module pragmatic_weight_encoder
  import pragmatic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [VEC_LENGTH-1:0][1:0]           shift_1st_sel,
  output logic [VEC_LENGTH-1:0]                shift_1st_en,
  output logic [1:0]                           shift_2nd_sel,
  output logic                                 shift_2nd_en,
  output logic [VEC_LENGTH-1:0]                is_neg,
  output logic                                 sched_first,
  output logic                                 sched_last,
  output logic                                 busy
);
  localparam logic signed [DATA_WIDTH:0] MAG_MAX = (DATA_WIDTH+1)'((1 << MAG_WIDTH) - 1);

  function automatic logic [MAG_WIDTH-1:0] sat_mag(input logic signed [DATA_WIDTH-1:0] w);
    logic signed [DATA_WIDTH:0] wx;
    logic signed [DATA_WIDTH:0] a;
    wx = {w[DATA_WIDTH-1], w};
    a  = wx[DATA_WIDTH] ? -wx : wx;
    if (a > MAG_MAX) a = MAG_MAX;
    return a[MAG_WIDTH-1:0];
  endfunction

  state_t                              r_state, w_state_nxt;
  logic                                r_act_done, r_act_first, r_pend_valid;
  logic [VEC_LENGTH-1:0][MAG_WIDTH-1:0] r_act_mask_p0, r_pend_mask_p0;
  logic [VEC_LENGTH-1:0]               r_act_neg_p0, r_pend_neg_p0;
  logic [VEC_LENGTH-1:0][MAG_WIDTH-1:0] w_in_mask, w_mask_nxt;
  logic [VEC_LENGTH-1:0]               w_in_neg, w_fire;
  logic [VEC_LENGTH-1:0][1:0]          w_s1;
  logic [2:0]                          w_minp;
  logic [1:0]                          w_base;
  logic                                w_load, w_release, w_acc, w_act_free, w_nxt_zero;
  lane_cmd_t [VEC_LENGTH-1:0]          w_cmd, r_cmd_p1;
  logic                                r_vld_p1, r_base_en_p1, r_first_p1, r_last_p1;
  logic [1:0]                          r_base_p1;

  always_comb begin
    for (int j = 0; j < VEC_LENGTH; j++) begin
      w_in_mask[j] = sat_mag(w_in[j]);
      w_in_neg[j]  = w_in[j][DATA_WIDTH-1];
    end
  end

  // Base selection: min lowest-bit across live lanes, clamped to the 2nd-stage range.
  always_comb begin
    w_minp = 3'd7;
    for (int j = 0; j < VEC_LENGTH; j++)
      if (lsb_pos(r_act_mask_p0[j]) < w_minp) w_minp = lsb_pos(r_act_mask_p0[j]);
    if (w_minp == 3'd7)               w_base = 2'd0;
    else if (w_minp > 3'(BASE_MAX))   w_base = 2'(BASE_MAX);
    else                              w_base = w_minp[1:0];
  end

  for (genvar g = 0; g < VEC_LENGTH; g++) begin : g_lane
    pragmatic_lane_pick u_pick (
      .i_mask     (r_act_mask_p0[g]),
      .i_base     (w_base),
      .o_fire     (w_fire[g]),
      .o_s1       (w_s1[g]),
      .o_mask_nxt (w_mask_nxt[g])
    );
  end

  always_comb begin
    for (int j = 0; j < VEC_LENGTH; j++) begin
      w_cmd[j].sel = w_s1[j];
      w_cmd[j].en  = w_fire[j];
      w_cmd[j].neg = r_act_neg_p0[j];
    end
  end

  assign w_nxt_zero = (w_mask_nxt == '0);
  assign w_load     = (!r_vld_p1 || out_ready) && (r_state == RUN) && !r_act_done;
  assign w_release  = r_vld_p1 && out_ready && r_last_p1;
  assign w_ready    = !reset && (!r_pend_valid || w_release);
  assign w_acc      = w_valid && w_ready;
  assign w_act_free = (r_state == IDLE) || w_release;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_state_nxt = RUN;
      RUN:     if (w_release && !r_pend_valid && !w_acc) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pend_valid <= 1'b0;
      r_act_done   <= 1'b1;
      r_act_first  <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_cmd_p1     <= '0;
      r_base_p1    <= '0;
      r_base_en_p1 <= 1'b0;
      r_first_p1   <= 1'b0;
      r_last_p1    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_vld_p1     <= 1'b1;
        r_cmd_p1     <= w_cmd;
        r_base_p1    <= w_base;
        r_base_en_p1 <= |w_fire;
        r_first_p1   <= r_act_first;
        r_last_p1    <= w_nxt_zero;
        r_act_first  <= 1'b0;
        r_act_done   <= w_nxt_zero;
      end else if (out_ready) begin
        r_vld_p1 <= 1'b0;
      end
      // Active slot refill: pending has priority, a fresh group only enters an empty pipe.
      if (w_act_free) begin
        if (r_pend_valid) begin
          r_act_done   <= 1'b0;
          r_act_first  <= 1'b1;
          r_pend_valid <= w_acc;
        end else if (w_acc) begin
          r_act_done  <= 1'b0;
          r_act_first <= 1'b1;
        end
      end else if (w_acc) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) r_act_mask_p0 <= w_mask_nxt;
    if (w_act_free) begin
      if (r_pend_valid) begin
        r_act_mask_p0 <= r_pend_mask_p0;
        r_act_neg_p0  <= r_pend_neg_p0;
      end else if (w_acc) begin
        r_act_mask_p0 <= w_in_mask;
        r_act_neg_p0  <= w_in_neg;
      end
    end
    if (w_acc) begin
      r_pend_mask_p0 <= w_in_mask;
      r_pend_neg_p0  <= w_in_neg;
    end
  end

  always_comb begin
    for (int j = 0; j < VEC_LENGTH; j++) begin
      shift_1st_sel[j] = r_cmd_p1[j].sel;
      shift_1st_en[j]  = r_cmd_p1[j].en;
      is_neg[j]        = r_cmd_p1[j].neg;
    end
  end

  assign out_valid     = r_vld_p1;
  assign shift_2nd_sel = r_base_p1;
  assign shift_2nd_en  = r_base_en_p1;
  assign sched_first   = r_first_p1;
  assign sched_last    = r_last_p1;
  assign busy          = ((r_state == RUN) && !r_act_done) || r_vld_p1;
endmodule

// File: tb/tb_pragmatic_weight_encoder.sv
// Directed table-driven bench for pragmatic_weight_encoder plus hand-written multi-cycle sequences.
module tb_pragmatic_weight_encoder;
  localparam int DW = 8;
  localparam int VL = 16;

  logic                 clk = 1'b0;
  logic                 reset, w_valid, out_ready;
  logic                 w_ready, out_valid, shift_2nd_en, sched_first, sched_last, busy;
  logic [VL-1:0][DW-1:0] w_in;
  logic [VL-1:0][1:0]   shift_1st_sel;
  logic [VL-1:0]        shift_1st_en, is_neg;
  logic [1:0]           shift_2nd_sel;

  always #5 clk = ~clk;

  pragmatic_weight_encoder #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_in(w_in),
    .out_valid(out_valid), .out_ready(out_ready), .shift_1st_sel(shift_1st_sel),
    .shift_1st_en(shift_1st_en), .shift_2nd_sel(shift_2nd_sel), .shift_2nd_en(shift_2nd_en),
    .is_neg(is_neg), .sched_first(sched_first), .sched_last(sched_last), .busy(busy)
  );

  typedef struct {
    logic [VL-1:0][DW-1:0] w;
    int                    ncmd;
    logic [VL-1:0]         en0;
    logic [VL-1:0][1:0]    sel0;
    logic [1:0]            b0;
    logic                  chk_b;
    logic                  sh2en0;
    logic [VL-1:0]         neg;
  } vec_t;

  vec_t vt[9];
  int total = 0;
  int bad = 0;

  logic [1:0]         rb[64];
  logic               rsh2[64], rfirst[64], rlast[64];
  logic [VL-1:0]      ren[64], rneg[64];
  logic [VL-1:0][1:0] rsel[64];

  int eb[7] = '{0, 1, 2, 3, 3, 3, 3};
  int es[7] = '{0, 0, 0, 0, 1, 2, 3};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [VL-1:0][DW-1:0] w);
    w_in    = w;
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
  endtask

  function automatic logic [7:0] mag_of(input logic [7:0] w);
    if (w == 8'h80) return 8'd127;
    else if (w[7]) return ~w + 8'd1;
    else return w;
  endfunction

  function automatic logic [127:0] snap();
    return {58'd0, out_valid, shift_1st_sel, shift_1st_en, shift_2nd_sel, shift_2nd_en,
            is_neg, sched_first, sched_last};
  endfunction

  task automatic collect(output int n);
    bit done;
    done = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (out_valid && n < 64) begin
        rb[n] = shift_2nd_sel;   rsh2[n] = shift_2nd_en; ren[n] = shift_1st_en;
        rsel[n] = shift_1st_sel; rneg[n] = is_neg;
        rfirst[n] = sched_first; rlast[n] = sched_last;
        n++;
        if (sched_last) done = 1'b1;
      end
    end
    check("collect_done", done, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, firsts, lasts, negbad, found;
    int sums[VL];
    logic [VL-1:0][7:0] recon, expmag;
    logic [127:0] s;
    logic [VL-1:0][DW-1:0] g80, g1s, g0;

    g80 = {{15{8'h00}}, 8'h80};
    g1s = {VL{8'h01}};
    g0  = {VL{8'h00}};

    vt[0] = '{{VL{8'h01}}, 1, 16'hFFFF, 32'h0, 2'd0, 1'b1, 1'b1, 16'h0000};
    vt[1] = '{{VL{8'h00}}, 1, 16'h0000, 32'h0, 2'd0, 1'b0, 1'b0, 16'h0000};
    vt[2] = '{{{15{8'h00}}, 8'h80}, 7, 16'h0001, 32'h0, 2'd0, 1'b1, 1'b1, 16'h0001};
    vt[3] = '{{{14{8'h00}}, 8'h50, 8'h01}, 3, 16'h0001, 32'h0, 2'd0, 1'b1, 1'b1, 16'h0000};
    vt[4] = '{{VL{8'hFF}}, 1, 16'hFFFF, 32'h0, 2'd0, 1'b1, 1'b1, 16'hFFFF};
    vt[5] = '{{VL{8'h08}}, 1, 16'hFFFF, 32'h0, 2'd3, 1'b1, 1'b1, 16'h0000};
    vt[6] = '{{{14{8'h00}}, 8'hF0, 8'h70}, 3, 16'h0003, 32'h5, 2'd3, 1'b1, 1'b1, 16'h0002};
    vt[7] = '{{{13{8'h00}}, 8'h41, 16'h0000}, 2, 16'h0004, 32'h0, 2'd0, 1'b1, 1'b1, 16'h0000};
    vt[8] = '{{{10{8'h00}}, 8'h40, 8'h00, 8'h7F, 24'h0}, 7, 16'h0008, 32'h0, 2'd0, 1'b1, 1'b1, 16'h0000};

    reset = 1'b1; w_valid = 1'b0; out_ready = 1'b1; w_in = '0;
    tick(); tick();
    check("reset_outs", {out_valid, w_ready, busy, shift_2nd_en, shift_1st_en, sched_first, sched_last}, '0);
    reset = 1'b0;
    tick();
    check("reset_wready", w_ready, 1'b1);

    for (int i = 0; i < 9; i++) begin
      check($sformatf("v%0d_wready", i), w_ready, 1'b1);
      send(vt[i].w);
      check($sformatf("v%0d_lat", i), {out_valid, busy}, 2'b01);
      collect(n);
      check($sformatf("v%0d_ncmd", i), n, vt[i].ncmd);
      check($sformatf("v%0d_en0", i), ren[0], vt[i].en0);
      check($sformatf("v%0d_sel0", i), rsel[0], vt[i].sel0);
      check($sformatf("v%0d_sh2en0", i), rsh2[0], vt[i].sh2en0);
      if (vt[i].chk_b) check($sformatf("v%0d_b0", i), rb[0], vt[i].b0);
      firsts = 0; lasts = 0; negbad = 0;
      for (int l = 0; l < VL; l++) sums[l] = 0;
      for (int k = 0; k < n; k++) begin
        firsts += int'(rfirst[k]);
        lasts  += int'(rlast[k]);
        if (rneg[k] !== vt[i].neg) negbad++;
        for (int l = 0; l < VL; l++)
          if (ren[k][l]) sums[l] += 1 << (int'(rb[k]) + int'(rsel[k][l]));
      end
      for (int l = 0; l < VL; l++) begin
        recon[l]  = 8'(sums[l]);
        expmag[l] = mag_of(vt[i].w[l]);
      end
      check($sformatf("v%0d_first", i), {rfirst[0], 8'(firsts)}, {1'b1, 8'd1});
      check($sformatf("v%0d_last", i), lasts, 1);
      check($sformatf("v%0d_neg", i), negbad, 0);
      check($sformatf("v%0d_recon", i), recon, expmag);
      tick(); tick();
    end

    // -128: full base/offset walk on lane 0
    send(g80);
    collect(n);
    for (int k = 0; k < 7; k++)
      check($sformatf("m128_step%0d", k), {rb[k], rsel[k][0], ren[k], rlast[k]},
            {2'(eb[k]), 2'(es[k]), 16'h0001, (k == 6)});
    tick(); tick();

    // lane0=0x01, lane1=0x50: lane 1 stalls until the base moves
    send(vt[3].w);
    collect(n);
    check("mix_c1", {rb[0], ren[0], rsel[0], rlast[0]}, {2'd0, 16'h0001, 32'h0, 1'b0});
    check("mix_c2", {rb[1], ren[1], rsel[1], rlast[1]}, {2'd3, 16'h0002, 32'h4, 1'b0});
    check("mix_c3", {rb[2], ren[2], rsel[2], rlast[2]}, {2'd3, 16'h0002, 32'hC, 1'b1});
    tick(); tick();

    // Back-pressure: hold for 5 cycles on the second command
    send(g80);
    tick();
    check("stall_c1", {out_valid, shift_2nd_sel, sched_first}, {1'b1, 2'd0, 1'b1});
    tick();
    check("stall_c2", {out_valid, shift_2nd_sel, shift_1st_en}, {1'b1, 2'd1, 16'h0001});
    out_ready = 1'b0;
    s = snap();
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall_hold%0d", k), snap(), s);
    end
    out_ready = 1'b1;
    for (int k = 2; k < 7; k++) begin
      tick();
      check($sformatf("stall_resume%0d", k), {out_valid, shift_2nd_sel, shift_1st_sel[0], shift_1st_en, sched_last},
            {1'b1, 2'(eb[k]), 2'(es[k]), 16'h0001, (k == 6)});
    end
    tick(); tick();

    // Back-to-back: g1 active, g2 pending, g3 accepted during the handover
    check("b2b_wr0", w_ready, 1'b1);
    send(g80);
    check("b2b_wr1", w_ready, 1'b1);
    send(g1s);
    check("b2b_wr_drop", w_ready, 1'b0);
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (out_valid && sched_last) found = 1;
      else tick();
    end
    check("b2b_last_seen", found, 1);
    check("b2b_wr_handover", w_ready, 1'b1);
    send(g0);
    check("b2b_bubble", {out_valid, busy, w_ready}, 3'b010);
    tick();
    check("b2b_g2_cmd", {out_valid, sched_first, sched_last, shift_1st_en, shift_2nd_en},
          {3'b111, 16'hFFFF, 1'b1});
    tick(); tick();
    check("b2b_g3_cmd", {out_valid, sched_first, sched_last, shift_1st_en, shift_2nd_en},
          {3'b111, 16'h0000, 1'b0});
    tick();
    check("b2b_idle", {out_valid, busy}, 2'b00);
    tick();

    // Reset in the middle of a group
    send(g80);
    tick(); tick();
    check("rst_pre", {out_valid, busy}, 2'b11);
    reset = 1'b1;
    tick();
    check("rst_mid", {out_valid, busy, w_ready}, 3'b000);
    reset = 1'b0;
    tick();
    check("rst_after", {w_ready, out_valid, busy}, 3'b100);
    tick(); tick();
    check("rst_quiet", {out_valid, busy}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
